// File: rtl/exception_controller.sv
// Exception/interrupt sequencer: latches masked cause lines, arbitrates at instruction boundaries,
// saves EPC, vectors the PC and restores it on eret. Define EXC_VECTORED_EN for per-cause vectors.
module exception_controller #(
    parameter int unsigned NUM_CAUSES = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MASK_LSB = 4,
    parameter logic [WIDTH-1:0] VEC_BASE = 16'h0010,
    localparam int unsigned TW = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [NUM_CAUSES-1:0] cause_req,
    input  logic [WIDTH-1:0]      status,
    input  logic                  commit,
    input  logic                  exc_ack,
    input  logic                  eret,
    input  logic [WIDTH-1:0]      epc_in,
    output logic                  exc_valid,
    output logic [TW-1:0]         ExType,
    output logic                  KernelMode,
    output logic                  pc_load,
    output logic [WIDTH-1:0]      pc_target,
    output logic [WIDTH-1:0]      epc_out,
    output logic [NUM_CAUSES-1:0] pending,
    output logic [NUM_CAUSES-1:0] cause_clr
);

    typedef enum logic [2:0] {
        StIdle, StReq, StSave, StVector, StKernel, StRet
    } state_e;

    state_e                state_q;
    logic [TW-1:0]         ex_type_q;
    logic [NUM_CAUSES-1:0] pending_q;
    logic [WIDTH-1:0]      epc_q;

    logic [NUM_CAUSES-1:0] eligible;
    logic [NUM_CAUSES-1:0] clear_mask;
    logic [TW-1:0]         winner;
    logic [WIDTH-1:0]      vector;
    logic                  unused_status;

    // Only the enable field of the status word is consumed here.
    assign unused_status = ^status;

    assign eligible = (pending_q | cause_req) & status[MASK_LSB +: NUM_CAUSES];

    // Scan from the top so the lowest-numbered eligible cause is the last assignment.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_CAUSES) - 1; i >= 0; i--) begin
            if (eligible[i]) winner = TW'(i);
        end
    end

    assign clear_mask = (state_q == StSave) ? (NUM_CAUSES'(1) << ex_type_q) : '0;

`ifdef EXC_VECTORED_EN
    assign vector = VEC_BASE + (WIDTH'(ex_type_q) << 2);
`else
    assign vector = VEC_BASE;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            ex_type_q <= '0;
            pending_q <= '0;
            epc_q     <= '0;
        end else begin
            // A request arriving alongside its own clear keeps the bit set.
            pending_q <= (pending_q & ~clear_mask) | cause_req;
            unique case (state_q)
                StIdle: begin
                    if (commit && (eligible != '0)) begin
                        ex_type_q <= winner;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (exc_ack) state_q <= StSave;
                end
                StSave: begin
                    epc_q   <= epc_in;
                    state_q <= StVector;
                end
                StVector: state_q <= StKernel;
                StKernel: begin
                    if (eret) state_q <= StRet;
                end
                StRet:    state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Moore outputs decoded from state and registers only.
    always_comb begin
        exc_valid  = (state_q == StReq);
        KernelMode = (state_q == StSave) || (state_q == StVector) ||
                     (state_q == StKernel) || (state_q == StRet);
        pc_load    = (state_q == StVector) || (state_q == StRet);
        pc_target  = '0;
        if (state_q == StVector) pc_target = vector;
        else if (state_q == StRet) pc_target = epc_q;
    end

    assign ExType    = ex_type_q;
    assign epc_out   = epc_q;
    assign pending   = pending_q;
    assign cause_clr = clear_mask;

endmodule

// File: tb/tb_exception_controller.sv
// Directed table-driven bench for exception_controller, plus hand sequences for the
// clear collision and reset-in-REQ corner cases.
module tb_exception_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cause_req;
    logic [15:0] status;
    logic        commit, exc_ack, eret;
    logic [15:0] epc_in;
    logic        exc_valid;
    logic [1:0]  ex_type;
    logic        kernel_mode, pc_load;
    logic [15:0] pc_target, epc_out;
    logic [3:0]  pending, cause_clr;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [3:0]  req;
        logic [15:0] status;
        logic        commit;
        logic        ack;
        logic        eret;
        logic [15:0] epc;
    } vin_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  ext;
        logic        km;
        logic        pcl;
        logic [15:0] tgt;
        logic [15:0] epc;
        logic [3:0]  pend;
        logic [3:0]  clr;
    } vout_t;

    typedef struct {
        vin_t  i;
        vout_t o;
    } vec_t;

    vec_t tbl[$];

`ifdef EXC_VECTORED_EN
    localparam logic [15:0] V1 = 16'h0014;
    localparam logic [15:0] V2 = 16'h0018;
    localparam logic [15:0] V3 = 16'h001C;
`else
    localparam logic [15:0] V1 = 16'h0010;
    localparam logic [15:0] V2 = 16'h0010;
    localparam logic [15:0] V3 = 16'h0010;
`endif

    exception_controller dut (
        .CLK        (clk),
        .Reset      (rst),
        .cause_req  (cause_req),
        .status     (status),
        .commit     (commit),
        .exc_ack    (exc_ack),
        .eret       (eret),
        .epc_in     (epc_in),
        .exc_valid  (exc_valid),
        .ExType     (ex_type),
        .KernelMode (kernel_mode),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .epc_out    (epc_out),
        .pending    (pending),
        .cause_clr  (cause_clr)
    );

    always #5 clk = ~clk;

    function automatic vout_t observe();
        vout_t o;
        o = '{valid: exc_valid, ext: ex_type, km: kernel_mode, pcl: pc_load,
              tgt: pc_target, epc: epc_out, pend: pending, clr: cause_clr};
        return o;
    endfunction

    task automatic check(input string name, input vout_t exp);
        vout_t got;
        got = observe();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got v=%b t=%0d km=%b pl=%b tgt=%h epc=%h pend=%b clr=%b, want v=%b t=%0d km=%b pl=%b tgt=%h epc=%h pend=%b clr=%b",
                     name, got.valid, got.ext, got.km, got.pcl, got.tgt, got.epc, got.pend,
                     got.clr, exp.valid, exp.ext, exp.km, exp.pcl, exp.tgt, exp.epc, exp.pend,
                     exp.clr);
        end
    endtask

    task automatic apply(input vin_t v);
        cause_req = v.req;
        status    = v.status;
        commit    = v.commit;
        exc_ack   = v.ack;
        eret      = v.eret;
        epc_in    = v.epc;
    endtask

    task automatic add(input vin_t i, input vout_t o);
        vec_t r;
        r.i = i;
        r.o = o;
        tbl.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        apply('0);

        // in: req status commit ack eret epc | out: valid ext km pcl tgt epc pend clr
        // Single cause
        add({4'b0100, 16'h00F0, 3'b100, 16'h0040}, {1'b1, 2'd2, 2'b00, 16'h0000, 16'h0000, 4'b0100, 4'b0000});
        add({4'b0000, 16'h00F0, 3'b000, 16'h0040}, {1'b1, 2'd2, 2'b00, 16'h0000, 16'h0000, 4'b0100, 4'b0000});
        add({4'b0000, 16'h00F0, 3'b010, 16'h0040}, {1'b0, 2'd2, 2'b10, 16'h0000, 16'h0000, 4'b0100, 4'b0100});
        add({4'b0000, 16'h00F0, 3'b000, 16'h0040}, {1'b0, 2'd2, 2'b11, V2,        16'h0040, 4'b0000, 4'b0000});
        add({4'b0000, 16'h00F0, 3'b000, 16'h0040}, {1'b0, 2'd2, 2'b10, 16'h0000, 16'h0040, 4'b0000, 4'b0000});
        add({4'b0000, 16'h00F0, 3'b001, 16'h0040}, {1'b0, 2'd2, 2'b11, 16'h0040, 16'h0040, 4'b0000, 4'b0000});
        add({4'b0000, 16'h00F0, 3'b000, 16'h0040}, {1'b0, 2'd2, 2'b00, 16'h0000, 16'h0040, 4'b0000, 4'b0000});
        // Priority and masking, new cause during kernel, return
        add({4'b1011, 16'h00E0, 3'b100, 16'h0123}, {1'b1, 2'd1, 2'b00, 16'h0000, 16'h0040, 4'b1011, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b010, 16'h0123}, {1'b0, 2'd1, 2'b10, 16'h0000, 16'h0040, 4'b1011, 4'b0010});
        add({4'b0000, 16'h00E0, 3'b000, 16'h0123}, {1'b0, 2'd1, 2'b11, V1,        16'h0123, 4'b1001, 4'b0000});
        add({4'b0010, 16'h00E0, 3'b000, 16'h0123}, {1'b0, 2'd1, 2'b10, 16'h0000, 16'h0123, 4'b1011, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b001, 16'h0123}, {1'b0, 2'd1, 2'b11, 16'h0123, 16'h0123, 4'b1011, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b000, 16'h0123}, {1'b0, 2'd1, 2'b00, 16'h0000, 16'h0123, 4'b1011, 4'b0000});
        // Pending cause 1 taken at first commit after return
        add({4'b0000, 16'h00E0, 3'b100, 16'h0200}, {1'b1, 2'd1, 2'b00, 16'h0000, 16'h0123, 4'b1011, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b010, 16'h0200}, {1'b0, 2'd1, 2'b10, 16'h0000, 16'h0123, 4'b1011, 4'b0010});
        add({4'b0000, 16'h00E0, 3'b000, 16'h0200}, {1'b0, 2'd1, 2'b11, V1,        16'h0200, 4'b1001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b001, 16'h0200}, {1'b0, 2'd1, 2'b10, 16'h0000, 16'h0200, 4'b1001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b001, 16'h0200}, {1'b0, 2'd1, 2'b11, 16'h0200, 16'h0200, 4'b1001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b110, 16'h0200}, {1'b0, 2'd1, 2'b00, 16'h0000, 16'h0200, 4'b1001, 4'b0000});
        // Cause 3 next; masked cause 0 never taken
        add({4'b0000, 16'h00E0, 3'b100, 16'h0300}, {1'b1, 2'd3, 2'b00, 16'h0000, 16'h0200, 4'b1001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b010, 16'h0300}, {1'b0, 2'd3, 2'b10, 16'h0000, 16'h0200, 4'b1001, 4'b1000});
        add({4'b0000, 16'h00E0, 3'b000, 16'h0300}, {1'b0, 2'd3, 2'b11, V3,        16'h0300, 4'b0001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b000, 16'h0300}, {1'b0, 2'd3, 2'b10, 16'h0000, 16'h0300, 4'b0001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b001, 16'h0300}, {1'b0, 2'd3, 2'b11, 16'h0300, 16'h0300, 4'b0001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b100, 16'h0300}, {1'b0, 2'd3, 2'b00, 16'h0000, 16'h0300, 4'b0001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b100, 16'h0300}, {1'b0, 2'd3, 2'b00, 16'h0000, 16'h0300, 4'b0001, 4'b0000});
        add({4'b0000, 16'h00E0, 3'b010, 16'h0300}, {1'b0, 2'd3, 2'b00, 16'h0000, 16'h0300, 4'b0001, 4'b0000});

        @(negedge clk);
        check("reset_state", '0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].i);
            step();
            check($sformatf("row%0d", k), tbl[k].o);
        end
        apply('0);

        // Clear collision: cause_req[2] held through SAVE keeps pending[2]
        rst = 1'b1;
        @(negedge clk);
        check("reset_again", '0);
        rst = 1'b0;
        apply({4'b0100, 16'h00F0, 3'b100, 16'h0500});
        step();
        check("coll_req", {1'b1, 2'd2, 2'b00, 16'h0000, 16'h0000, 4'b0100, 4'b0000});
        apply({4'b0100, 16'h00F0, 3'b010, 16'h0500});
        step();
        check("coll_save", {1'b0, 2'd2, 2'b10, 16'h0000, 16'h0000, 4'b0100, 4'b0100});
        apply({4'b0100, 16'h00F0, 3'b000, 16'h0500});
        step();
        check("coll_vector", {1'b0, 2'd2, 2'b11, V2, 16'h0500, 4'b0100, 4'b0000});
        apply({4'b0000, 16'h00F0, 3'b000, 16'h0500});
        step();
        check("coll_kernel", {1'b0, 2'd2, 2'b10, 16'h0000, 16'h0500, 4'b0100, 4'b0000});

        // Reset while exc_valid=1 clears everything without waiting for a clock edge
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply({4'b0010, 16'h00F0, 3'b100, 16'h0600});
        step();
        check("rreq_pre", {1'b1, 2'd1, 2'b00, 16'h0000, 16'h0000, 4'b0010, 4'b0000});
        apply({4'b0000, 16'h00F0, 3'b000, 16'h0600});
        #2 rst = 1'b1;
        #1 check("rreq_async", '0);
        @(negedge clk);
        rst = 1'b0;
        apply({4'b0000, 16'h00F0, 3'b010, 16'h0600});
        step();
        check("rreq_ack_ignored", '0);
        apply({4'b0000, 16'h00F0, 3'b000, 16'h0600});
        step();
        check("rreq_idle", '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
